// File: rtl/instruction_memory_loadable.sv
// Loadable synchronous-read instruction memory with a streaming program-load port.
// Two states: RUN serves one fetch per cycle; LOAD accepts one program word per cycle.
module instruction_memory_loadable #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 64,
  parameter logic [DATA_W-1:0] HALT_WORD = 'hE000
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         fetch_req_i,
  input  logic [ADDR_W-1:0]            fetch_addr_i,
  output logic                         fetch_valid_o,
  output logic [DATA_W-1:0]            fetch_data_o,
  output logic                         fetch_err_o,
  output logic                         fetch_stall_o,
  input  logic                         load_start_i,
  input  logic                         load_valid_i,
  output logic                         load_ready_o,
  input  logic [DATA_W-1:0]            load_data_i,
  input  logic                         load_last_i,
  output logic                         load_done_o,
  output logic [$clog2(DEPTH+1)-1:0]   load_count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                fetch_valid_q;
  logic                fetch_err_q;
  logic [DATA_W-1:0]   fetch_data_q;
  logic                load_done_q;

  // Contents start as halt words and are deliberately never touched by reset.
  logic [DATA_W-1:0]   mem_q [DEPTH] = '{default: HALT_WORD};

  logic                wr_en_d;
  logic                in_range_d;
  logic                last_word_d;

  always_comb begin
    wr_en_d     = !reset_i && (state_q == LOAD) && load_valid_i && !load_start_i;
    in_range_d  = fetch_addr_i < ADDR_W'(DEPTH);
    last_word_d = load_last_i || (cnt_q == CNT_W'(DEPTH - 1));
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_d) mem_q[cnt_q[PTR_W-1:0]] <= load_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_data_q  <= '0;
      load_done_q   <= 1'b0;
    end else begin
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      case (state_q)
        RUN: begin
          if (load_start_i) begin
            state_q <= LOAD;
            cnt_q   <= '0;
          end else if (fetch_req_i) begin
            fetch_valid_q <= 1'b1;
            if (in_range_d) begin
              fetch_data_q <= mem_q[fetch_addr_i[PTR_W-1:0]];
            end else begin
              fetch_data_q <= HALT_WORD;
              fetch_err_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          // A restart discards whatever word is offered in the same cycle.
          if (load_start_i) begin
            cnt_q <= '0;
          end else if (load_valid_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_word_d) begin
              state_q     <= RUN;
              load_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign fetch_valid_o = fetch_valid_q;
  assign fetch_data_o  = fetch_data_q;
  assign fetch_err_o   = fetch_err_q;
  assign fetch_stall_o = (state_q == LOAD);
  assign load_ready_o  = (state_q == LOAD);
  assign load_done_o   = load_done_q;
  assign load_count_o  = cnt_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench for instruction_memory_loadable: a behavioural model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_instruction_memory_loadable;

  localparam int DEPTH = 64;
  localparam logic [15:0] HALT = 16'hE000;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        fetch_req_i = 1'b0;
  logic [15:0] fetch_addr_i = '0;
  logic        fetch_valid_o;
  logic [15:0] fetch_data_o;
  logic        fetch_err_o;
  logic        fetch_stall_o;
  logic        load_start_i = 1'b0;
  logic        load_valid_i = 1'b0;
  logic        load_ready_o;
  logic [15:0] load_data_i = '0;
  logic        load_last_i = 1'b0;
  logic        load_done_o;
  logic [6:0]  load_count_o;

  instruction_memory_loadable dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_valid_o(fetch_valid_o), .fetch_data_o(fetch_data_o),
    .fetch_err_o(fetch_err_o), .fetch_stall_o(fetch_stall_o),
    .load_start_i(load_start_i), .load_valid_i(load_valid_i),
    .load_ready_o(load_ready_o), .load_data_i(load_data_i),
    .load_last_i(load_last_i), .load_done_o(load_done_o),
    .load_count_o(load_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a program store plus "are we loading" and "how many written".
  logic [15:0] model_mem [DEPTH];
  bit          m_loading = 0;
  int          m_written = 0;
  bit          m_valid = 0, m_err = 0, m_done = 0;
  logic [15:0] m_data = '0;

  initial for (int i = 0; i < DEPTH; i++) model_mem[i] = HALT;

  always @(posedge clk_i) begin
    if (reset_i) begin
      m_loading = 0; m_written = 0; m_valid = 0; m_err = 0; m_data = '0; m_done = 0;
    end else begin
      m_valid = 0; m_err = 0; m_done = 0;
      if (!m_loading) begin
        if (load_start_i) begin
          m_loading = 1; m_written = 0;
        end else if (fetch_req_i) begin
          m_valid = 1;
          if (int'(fetch_addr_i) < DEPTH) m_data = model_mem[fetch_addr_i];
          else begin m_data = HALT; m_err = 1; end
        end
      end else if (load_start_i) begin
        m_written = 0;
      end else if (load_valid_i) begin
        model_mem[m_written] = load_data_i;
        m_written = m_written + 1;
        if (load_last_i || m_written == DEPTH) begin m_loading = 0; m_done = 1; end
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("fetch_valid", 32'(fetch_valid_o), 32'(m_valid));
      chk("fetch_err", 32'(fetch_err_o), 32'(m_err));
      chk("fetch_data", 32'(fetch_data_o), 32'(m_data));
      chk("fetch_stall", 32'(fetch_stall_o), 32'(m_loading));
      chk("load_ready", 32'(load_ready_o), 32'(m_loading));
      chk("load_done", 32'(load_done_o), 32'(m_done));
      chk("load_count", 32'(load_count_o), 32'(m_written));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one fetch; outputs are checked one cycle later against literals.
  task automatic fetch_lit(input logic [15:0] addr, input logic [15:0] exp, input bit exp_err);
    fetch_req_i = 1'b1; fetch_addr_i = addr;
    step();
    chk("lit_valid", 32'(fetch_valid_o), 32'd1);
    chk("lit_data", 32'(fetch_data_o), 32'(exp));
    chk("lit_err", 32'(fetch_err_o), 32'(exp_err));
    chk("model_data", 32'(m_data), 32'(exp));
  endtask

  task automatic start_load();
    fetch_req_i = 1'b0; load_start_i = 1'b1;
    step();
    load_start_i = 1'b0;
    chk("ready_after_start", 32'(load_ready_o), 32'd1);
  endtask

  task automatic push(input logic [15:0] d, input bit last);
    load_valid_i = 1'b1; load_data_i = d; load_last_i = last;
    step();
    load_valid_i = 1'b0; load_last_i = 1'b0;
  endtask

  logic [15:0] prog [15] = '{16'hC00A, 16'h2000, 16'h3101, 16'h4202, 16'h5303,
                             16'h6404, 16'h7505, 16'h8606, 16'h9707, 16'hA808,
                             16'hB909, 16'hCA0A, 16'hDB0B, 16'h1C0C, 16'hE000};

  initial begin
    int acc, dn;
    step(); step();
    reset_i = 1'b0;
    chk_en = 1'b1;
    chk("rst_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst_data", 32'(fetch_data_o), 32'd0);
    chk("rst_count", 32'(load_count_o), 32'd0);
    chk("rst_ready", 32'(load_ready_o), 32'd0);

    // Power-up contents
    fetch_lit(16'd0, HALT, 0);
    fetch_lit(16'd1, HALT, 0);
    fetch_lit(16'd63, HALT, 0);
    fetch_req_i = 1'b0;
    step();

    // 15-word program
    start_load();
    for (int i = 0; i < 15; i++) push(prog[i], i == 14);
    chk("prog_done", 32'(load_done_o), 32'd1);
    chk("prog_count", 32'(load_count_o), 32'd15);
    chk("prog_stall", 32'(fetch_stall_o), 32'd0);
    fetch_lit(16'd14, 16'hE000, 0);
    chk("prog_done_pulse", 32'(load_done_o), 32'd0);
    for (int i = 0; i < 15; i++) fetch_lit(16'(i), prog[i], 0);

    // Out of range
    fetch_lit(16'd64, HALT, 1);
    fetch_lit(16'hFFFF, HALT, 1);
    fetch_lit(16'd63, HALT, 0);
    fetch_req_i = 1'b0;
    step();

    // Overflow: 70 words, no last
    start_load();
    acc = 0; dn = 0;
    for (int i = 0; i < 70; i++) begin
      if (load_ready_o) acc++;
      push(16'h5000 + 16'(i), 0);
      if (load_done_o) dn++;
    end
    chk("ovf_accepted", 32'(acc), 32'd64);
    chk("ovf_done_pulses", 32'(dn), 32'd1);
    chk("ovf_count", 32'(load_count_o), 32'd64);
    fetch_lit(16'd0, 16'h5000, 0);
    fetch_lit(16'd63, 16'h503F, 0);
    fetch_req_i = 1'b0;
    step();

    // Abort and restart
    start_load();
    for (int i = 0; i < 5; i++) push(16'hA000 + 16'(i), 0);
    load_start_i = 1'b1; load_valid_i = 1'b1; load_data_i = 16'hBEEF;
    fetch_req_i = 1'b1; fetch_addr_i = 16'd2;
    step();
    load_start_i = 1'b0; load_valid_i = 1'b0; fetch_req_i = 1'b0;
    chk("restart_count", 32'(load_count_o), 32'd0);
    chk("restart_no_done", 32'(load_done_o), 32'd0);
    chk("restart_fetch_valid", 32'(fetch_valid_o), 32'd0);
    chk("restart_stall", 32'(fetch_stall_o), 32'd1);
    push(16'h1111, 0);
    push(16'h2222, 0);
    push(16'h3333, 1);
    chk("restart_final_count", 32'(load_count_o), 32'd3);
    chk("restart_done", 32'(load_done_o), 32'd1);
    fetch_lit(16'd0, 16'h1111, 0);
    fetch_lit(16'd1, 16'h2222, 0);
    fetch_lit(16'd2, 16'h3333, 0);
    fetch_lit(16'd3, 16'hA003, 0);
    fetch_lit(16'd4, 16'hA004, 0);
    fetch_lit(16'd5, 16'h5005, 0);
    fetch_req_i = 1'b0;
    step();

    // Reset mid-load
    start_load();
    for (int i = 0; i < 4; i++) push(16'h7000 + 16'(i), 0);
    reset_i = 1'b1; load_valid_i = 1'b1; load_data_i = 16'hDEAD;
    step();
    reset_i = 1'b0; load_valid_i = 1'b0;
    chk("rst_mid_count", 32'(load_count_o), 32'd0);
    chk("rst_mid_ready", 32'(load_ready_o), 32'd0);
    chk("rst_mid_done", 32'(load_done_o), 32'd0);
    step();
    chk("rst_mid_done_after", 32'(load_done_o), 32'd0);
    for (int i = 0; i < 4; i++) fetch_lit(16'(i), 16'h7000 + 16'(i), 0);
    fetch_lit(16'd4, 16'hA004, 0);
    fetch_req_i = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_memory_loadable.md
# instruction_memory_loadable

Parametrised, loadable instruction memory for the single-cycle CPU family. Replaces a fixed combinational program ROM with a synchronous-read store that can be reprogrammed at run time through a streaming load port, so test programs can be swapped without re-elaborating the design. Sits between the program counter and the decoder; the loader port is driven by a testbench or a boot/debug master.

## Interface
- DATA_W, 16, instruction word width
- ADDR_W, 16, fetch address (PC) width
- DEPTH, 64, number of instruction words; addresses 0..DEPTH-1 valid
- HALT_WORD, 16'hE000, word returned for out-of-range fetches and power-up contents (hlt opcode)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch request this cycle
- fetch_addr  in  ADDR_W  word address of requested instruction
- fetch_valid  out  1  fetch_data holds response to request of previous cycle
- fetch_data  out  DATA_W  registered instruction word
- fetch_err  out  1  qualifies fetch_valid; response was out of range
- fetch_stall  out  1  high while in LOAD; fetches are not served
- load_start  in  1  pulse: enter LOAD, write pointer to 0
- load_valid  in  1  load_data offered
- load_ready  out  1  block accepts load word this cycle
- load_data  in  DATA_W  next program word
- load_last  in  1  with accepted word: final word of program
- load_done  out  1  one-cycle pulse when a load session ends
- load_count  out  $clog2(DEPTH+1)  words written in current/last session

## Operation
- Two states: RUN (reset state), LOAD.
- Memory contents initialised to HALT_WORD at time zero; reset does NOT clear memory; contents survive reset.
- RUN: fetch_req=1 with fetch_addr<DEPTH -> next cycle fetch_valid=1, fetch_data=mem[fetch_addr], fetch_err=0. fetch_addr>=DEPTH -> fetch_valid=1, fetch_data=HALT_WORD, fetch_err=1. fetch_req=0 -> fetch_valid=0, fetch_err=0, fetch_data holds last value.
- RUN: load_valid ignored, load_ready=0.
- RUN, load_start=1 -> LOAD; pointer=0, load_count=0. A fetch_req in the same cycle is dropped (fetch_valid=0 next cycle).
- LOAD: fetch_stall=1, load_ready=1; fetch_req ignored, fetch_valid=0.
- Accepted word (load_valid & load_ready): mem[pointer]=load_data, pointer+1, load_count+1.
- Session ends when accepted word has load_last=1 OR pointer reaches DEPTH-1 (word DEPTH-1 accepted) -> RUN, load_done pulse next cycle, load_count holds final value.
- load_start during LOAD: restarts session; pointer and load_count to 0; any load_valid word that cycle is discarded; no load_done pulse.
- Words beyond load_count keep previous contents.
- Reset: state=RUN, pointer=0, fetch_valid=0, fetch_err=0, fetch_data=0, fetch_stall=0, load_ready=0, load_done=0, load_count=0. Reset mid-load aborts the session; already written words remain; no load_done.
- Reset has priority over load_start, load_valid, fetch_req in the same cycle.

## Timing
- Fetch latency exactly 1 cycle; one fetch per cycle sustained in RUN; no bubbles.
- load_ready is a registered function of state (high from the cycle after load_start through the cycle the final word is accepted).
- Load throughput 1 word/cycle.
- load_done asserted exactly 1 cycle, the cycle after the terminating word is accepted; fetch_stall falls in that same cycle; a fetch_req in that cycle is served (response one cycle later).
- Write-then-read: a word written in cycle N is readable by a fetch issued in cycle N+1 or later (only possible after LOAD exit).
- All outputs registered; no combinational path input->output.

## Test plan
- Power-up fetch: after reset, fetch_req addr 0,1,63 -> fetch_valid=1 each next cycle, fetch_data=16'hE000, fetch_err=0.
- Load 15-word program (16'hC00A,16'h2000,...,16'hE000), load_last on word 15 -> load_count=15, load_done one pulse; then fetches addr 0..14 back-to-back return the words in order, 1-cycle latency, no gaps.
- Out of range: fetch addr 64 and 16'hFFFF -> fetch_data=16'hE000, fetch_err=1; addr 63 -> fetch_err=0.
- Overflow: 70 words offered with no load_last -> exactly 64 accepted, load_ready drops after word 64, load_count=64, load_done pulse, words 65-70 not written.
- Abort/restart: load 5 words, assert load_start again, load 3 words (16'h1111,16'h2222,16'h3333) with last -> addr 0..2 = new words, addr 3,4 = first-session words 3,4, load_count=3; fetch_req during LOAD -> fetch_valid stays 0, fetch_stall=1.
- Reset mid-load after 4 words -> state RUN, load_count=0, no load_done; addr 0..3 read the 4 written words, addr 4 reads prior content.
